snake_dir_ctrl: RTL and testbench

//  Consumes the one-cycle debounced key pulses (UP/DOWN/LEFT/RIGHT/MID) and produces the snake heading.

---
 rtl/snake_pkg.sv | 30 +++
 rtl/snake_dir_queue.sv | 71 +++++++
 rtl/snake_dir_ctrl.sv | 164 ++++++++++++++++
 tb/tb_snake_dir_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module  : snake_pkg
// Brief   : Shared heading/state encodings and helpers for the snake
//           direction controller.
// Rev     : 1.0  initial release
// ============================================================================
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_LEFT  = 2'd2;
  localparam dir_t DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  // Opposite heading: UP<->DOWN, LEFT<->RIGHT share bit 1 and differ in bit 0
  function automatic dir_t dir_reverse(input dir_t d);
    return {d[1], ~d[0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/snake_dir_queue.sv
`default_nettype none
// ============================================================================
// Module  : snake_dir_queue
// Brief   : 2-deep FIFO of pending headings. A simultaneous push and pop
//           removes the head first and then appends the new tail. The caller
//           never pushes when full without a pop, nor pops when empty.
// Rev     : 1.0  initial release
// ============================================================================
module snake_dir_queue
  import snake_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       push,
  input  logic       pop,
  input  dir_t       din,
  output dir_t       head,
  output dir_t       tail,
  output logic [1:0] count
);

  dir_t       r_mem0;
  dir_t       r_mem1;
  logic [1:0] r_count;

  // Storage and occupancy: slot 0 is always the head
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem0  <= DIR_UP;
      r_mem1  <= DIR_UP;
      r_count <= 2'd0;
    end else if (clear) begin
      r_count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_mem0  <= din;
            r_count <= 2'd1;
          end else if (r_count == 2'd1) begin
            r_mem1  <= din;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count != 2'd0) begin
            r_mem0  <= r_mem1;
            r_count <= r_count - 2'd1;
          end
        end
        2'b11: begin
          if (r_count == 2'd2) begin
            r_mem0 <= r_mem1;
            r_mem1 <= din;
          end else begin
            r_mem0  <= din;
            r_count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign head  = r_mem0;
  assign tail  = (r_count == 2'd2) ? r_mem1 : r_mem0;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : snake_dir_ctrl
// Brief   : Snake heading and run-state controller. Filters direction key
//           pulses (priority UP>DOWN>LEFT>RIGHT, no 180-degree reversals),
//           buffers pending turns and emits a registered move strobe per
//           game step.
// Config  : SNAKE_DIR_QUEUE_EN - 2-entry turn FIFO; otherwise a single
//           pending register where the last valid key wins.
// Rev     : 1.0  initial release
// ============================================================================
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter dir_t DIR_INIT = 2'd3
)
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_mid,
  input  logic       step_tick,
  input  logic       game_over,
  output logic [1:0] dir,
  output logic       move,
  output logic       running,
  output logic [1:0] state
);

  state_t r_state;
  dir_t   r_dir;
  logic   r_move;
  logic   r_running;

  logic   w_in_run;
  logic   w_step_run;
  logic   w_start;
  logic   w_key_any;
  dir_t   w_key;
  dir_t   w_ref;
  logic   w_key_ok;
  logic   w_new_valid;
  dir_t   w_new_dir;

  assign w_in_run   = (r_state == ST_RUN);
  assign w_step_run = step_tick && w_in_run;
  assign w_start    = (r_state == ST_IDLE) && key_mid;
  assign w_key_any  = key_up | key_down | key_left | key_right;

  // Single candidate key; lower-priority simultaneous presses are discarded
  always_comb begin
    w_key = DIR_RIGHT;
    if (key_up)         w_key = DIR_UP;
    else if (key_down)  w_key = DIR_DOWN;
    else if (key_left)  w_key = DIR_LEFT;
  end

  // A turn is useful only if it changes heading and is not a reversal
  assign w_key_ok = w_in_run && w_key_any &&
                    (w_key != w_ref) && (w_key != dir_reverse(w_ref));

`ifdef SNAKE_DIR_QUEUE_EN
  dir_t       w_q_head;
  dir_t       w_q_tail;
  logic [1:0] w_q_count;
  logic       w_q_pop;
  logic       w_q_push;

  assign w_ref    = (w_q_count != 2'd0) ? w_q_tail : r_dir;
  assign w_q_pop  = w_step_run && (w_q_count != 2'd0);
  assign w_q_push = w_key_ok && ((w_q_count != 2'd2) || w_q_pop);

  snake_dir_queue u_queue (
    .clk   (clk),
    .rstn  (rstn),
    .clear (w_start),
    .push  (w_q_push),
    .pop   (w_q_pop),
    .din   (w_key),
    .head  (w_q_head),
    .tail  (w_q_tail),
    .count (w_q_count)
  );

  assign w_new_valid = w_q_pop;
  assign w_new_dir   = w_q_head;
`else
  logic r_pend_valid;
  dir_t r_pend_dir;

  assign w_ref = r_dir;

  // Pending turn: a fresh key overwrites; a step consumes the previous value
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pend_valid <= 1'b0;
      r_pend_dir   <= DIR_UP;
    end else if (w_start) begin
      r_pend_valid <= 1'b0;
    end else if (w_key_ok) begin
      r_pend_valid <= 1'b1;
      r_pend_dir   <= w_key;
    end else if (w_step_run) begin
      r_pend_valid <= 1'b0;
    end
  end

  assign w_new_valid = w_step_run && r_pend_valid;
  assign w_new_dir   = r_pend_dir;
`endif

  // Run-state machine with registered heading, move strobe and running flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_INIT;
      r_move    <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_move <= w_step_run;
      if (w_new_valid) r_dir <= w_new_dir;
      case (r_state)
        ST_IDLE: begin
          if (key_mid) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_dir     <= DIR_INIT;
          end
        end
        ST_RUN: begin
          if (game_over) begin
            r_state   <= ST_OVER;
            r_running <= 1'b0;
          end else if (key_mid) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (game_over) begin
            r_state <= ST_OVER;
          end else if (key_mid) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end
        end
        ST_OVER: begin
          if (key_mid) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dir     = r_dir;
  assign move    = r_move;
  assign running = r_running;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_snake_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_snake_dir_ctrl
// Brief   : Directed self-checking bench for snake_dir_ctrl. Inputs change
//           on the falling edge; outputs are sampled on the falling edge
//           following the rising edge that consumed them.
// Rev     : 1.0  initial release
// ============================================================================
module tb_snake_dir_ctrl;

  // {up, down, left, right, mid, step}
  localparam logic [5:0] K_UP    = 6'b100000;
  localparam logic [5:0] K_DOWN  = 6'b010000;
  localparam logic [5:0] K_LEFT  = 6'b001000;
  localparam logic [5:0] K_RIGHT = 6'b000100;
  localparam logic [5:0] K_MID   = 6'b000010;
  localparam logic [5:0] K_STEP  = 6'b000001;

`ifdef SNAKE_DIR_QUEUE_EN
  localparam logic [1:0] E_STEP1 = 2'd0;
  localparam logic [1:0] E_STEP2 = 2'd2;
`else
  localparam logic [1:0] E_STEP1 = 2'd1;
  localparam logic [1:0] E_STEP2 = 2'd1;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_up, key_down, key_left, key_right, key_mid, step_tick;
  logic       game_over;
  logic [1:0] dir;
  logic       move;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  snake_dir_ctrl #(.DIR_INIT(2'd3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .key_mid   (key_mid),
    .step_tick (step_tick),
    .game_over (game_over),
    .dir       (dir),
    .move      (move),
    .running   (running),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of pulses, return on the next falling edge
  task automatic cyc(input logic [5:0] v);
    {key_up, key_down, key_left, key_right, key_mid, step_tick} = v;
    @(negedge clk);
    {key_up, key_down, key_left, key_right, key_mid, step_tick} = 6'b0;
  endtask

  initial begin
    rstn = 1'b0;
    game_over = 1'b0;
    {key_up, key_down, key_left, key_right, key_mid, step_tick} = 6'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    check_eq("rst_state",   8'(state),   8'd0);
    check_eq("rst_dir",     8'(dir),     8'd3);
    check_eq("rst_move",    8'(move),    8'd0);
    check_eq("rst_running", 8'(running), 8'd0);

    // 1: start and first step
    cyc(K_MID);
    check_eq("start_state",   8'(state),   8'd1);
    check_eq("start_running", 8'(running), 8'd1);
    check_eq("start_dir",     8'(dir),     8'd3);
    cyc(K_STEP);
    check_eq("step1_move", 8'(move), 8'd1);
    check_eq("step1_dir",  8'(dir),  8'd3);
    cyc(6'b0);
    check_eq("move_width", 8'(move), 8'd0);

    // 2: reversal rejected, perpendicular accepted
    cyc(K_LEFT);
    cyc(K_STEP);
    check_eq("rev_move", 8'(move), 8'd1);
    check_eq("rev_dir",  8'(dir),  8'd3);
    cyc(K_UP);
    cyc(K_STEP);
    check_eq("up_dir", 8'(dir), 8'd0);
    cyc(K_RIGHT);
    cyc(K_STEP);
    check_eq("right_dir", 8'(dir), 8'd3);

    // 3: quick presses, third key while full
    cyc(K_UP);
    cyc(K_LEFT);
    cyc(K_DOWN);
    cyc(K_STEP);
    check_eq("quick_step1", 8'(dir), 8'(E_STEP1));
    cyc(K_STEP);
    check_eq("quick_step2", 8'(dir), 8'(E_STEP2));
    check_eq("quick_move2", 8'(move), 8'd1);
    cyc(K_LEFT);
    cyc(K_STEP);
    check_eq("realign_dir", 8'(dir), 8'd2);

    // 4: simultaneous keys, priority selection
    cyc(K_UP | K_LEFT);
    cyc(K_STEP);
    check_eq("prio_up_left", 8'(dir), 8'd0);
    cyc(K_DOWN | K_RIGHT);
    cyc(K_STEP);
    check_eq("prio_down_right", 8'(dir), 8'd0);

    // 5: pause keeps pending turn, ignores keys and steps
    cyc(K_RIGHT);
    cyc(K_MID);
    check_eq("pause_state",   8'(state),   8'd2);
    check_eq("pause_running", 8'(running), 8'd0);
    cyc(K_STEP);
    check_eq("pause_move", 8'(move), 8'd0);
    check_eq("pause_dir",  8'(dir),  8'd0);
    cyc(K_LEFT);
    cyc(K_MID);
    check_eq("resume_state", 8'(state), 8'd1);
    cyc(K_STEP);
    check_eq("resume_dir",  8'(dir),  8'd3);
    check_eq("resume_move", 8'(move), 8'd1);

    // 6: game over priority, restart, async reset mid-step
    cyc(K_UP);
    cyc(K_STEP);
    check_eq("pre_over_dir", 8'(dir), 8'd0);
    game_over = 1'b1;
    cyc(K_MID);
    game_over = 1'b0;
    check_eq("over_state",   8'(state),   8'd3);
    check_eq("over_running", 8'(running), 8'd0);
    cyc(K_STEP);
    check_eq("over_move", 8'(move), 8'd0);
    cyc(K_MID);
    check_eq("idle_state", 8'(state), 8'd0);
    cyc(K_MID);
    check_eq("restart_state", 8'(state), 8'd1);
    check_eq("restart_dir",   8'(dir),   8'd3);
    cyc(K_UP);
    cyc(K_STEP);
    check_eq("final_up_dir", 8'(dir), 8'd0);
    cyc(K_RIGHT);
    step_tick = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check_eq("arst_state",   8'(state),   8'd0);
    check_eq("arst_dir",     8'(dir),     8'd3);
    check_eq("arst_move",    8'(move),    8'd0);
    check_eq("arst_running", 8'(running), 8'd0);
    @(negedge clk);
    step_tick = 1'b0;
    rstn = 1'b1;
    cyc(K_MID);
    cyc(K_STEP);
    check_eq("post_rst_dir", 8'(dir), 8'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
